acl2_spi_responder: RTL and testbench

//  SPI-slave model of the ADXL362 accelerometer command protocol: the responding end of the glove's

---
 rtl/acl2_spi_responder_if.sv | 27 ++
 rtl/acl2_spi_responder.sv | 200 ++++++++++++++++++++
 tb/tb_acl2_spi_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acl2_spi_responder_if.sv
// Signal bundle between an SPI host and the ADXL362-style responder.
// The master side drives the SPI pins and the sample feed. The slave side answers and reports writes.
interface acl2_spi_responder_if;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        sample_valid;
    logic [15:0] x_sample;
    logic [15:0] y_sample;
    logic [15:0] z_sample;
    logic        int2;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  power_ctl;

    modport master (
        output sclk, ss, mosi, sample_valid, x_sample, y_sample, z_sample,
        input  miso, int2, wr_strobe, wr_addr, wr_data, power_ctl
    );

    modport slave (
        input  sclk, ss, mosi, sample_valid, x_sample, y_sample, z_sample,
        output miso, int2, wr_strobe, wr_addr, wr_data, power_ctl
    );
endinterface

// File: rtl/acl2_spi_responder.sv
// SPI mode-0 responder modelling the ADXL362 register protocol (WRITE_REG 0x0A / READ_REG 0x0B).
// It has a 64-byte register file, coherent X/Y/Z sample registers and a data-ready interrupt.
module acl2_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_VAL   = 8'hAD
) (
    input  logic                clk,
    input  logic                rst,
    acl2_spi_responder_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h0A;
    localparam logic [7:0] CMD_READ    = 8'h0B;
    localparam logic [5:0] ADDR_STATUS = 6'h0B;
    localparam logic [5:0] ADDR_XL     = 6'h0E;
    localparam logic [5:0] ADDR_PWR    = 6'h2D;

    // Each stage holds {sclk, ss, mosi}. The idle value has ss high.
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic [SYNC_STAGES-1:0][2:0] sync_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_in
                assign sync_d[gi] = {bus.sclk, bus.ss, bus.mosi};
            end else begin : g_chain
                assign sync_d[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) sync_reg <= {SYNC_STAGES{3'b010}};
        else     sync_reg <= sync_d;
    end

    logic sclk_s, ss_s, mosi_s;
    assign {sclk_s, ss_s, mosi_s} = sync_reg[SYNC_STAGES-1];

    logic sclk_prev_reg, ss_prev_reg;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign ss_fall   = ~ss_s & ss_prev_reg;
    assign ss_rise   = ss_s & ~ss_prev_reg;

    logic [2:0]  bit_cnt_reg;
    logic [6:0]  rx_shift_reg;
    logic [7:0]  tx_shift_reg;
    logic [7:0]  rx_byte;
    logic        byte_done;
    assign rx_byte   = {rx_shift_reg, mosi_s};
    assign byte_done = sclk_rise & ~ss_s & (bit_cnt_reg == 3'd7);

    state_t      state_reg, state_next;
    logic        wr_mode_reg, wr_mode_next;
    logic [5:0]  ptr_reg, ptr_next;
    logic [5:0]  load_addr;
    logic        load_tx, do_write;

    logic [7:0]  regs_reg [64];
    logic        wr_strobe_reg, int2_reg, pending_reg, clr_reg;
    logic [7:0]  wr_addr_reg, wr_data_reg;
    logic [47:0] shadow_reg, shadow_next;
    logic        copy_en;

    function automatic logic is_ro(input logic [5:0] a);
        return (a == 6'h00) || (a == ADDR_STATUS) || (a >= 6'h0E && a <= 6'h13);
    endfunction

    // The falling edge right after a byte boundary must not shift. That edge leaves the freshly loaded MSB on miso.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_reg <= 1'b0;
            ss_prev_reg   <= 1'b1;
            bit_cnt_reg   <= 3'd0;
            rx_shift_reg  <= 7'd0;
            tx_shift_reg  <= 8'd0;
        end else begin
            sclk_prev_reg <= sclk_s;
            ss_prev_reg   <= ss_s;
            if (ss_s) begin
                bit_cnt_reg  <= 3'd0;
                tx_shift_reg <= 8'd0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                    rx_shift_reg <= rx_byte[6:0];
                end
                if (load_tx)
                    tx_shift_reg <= regs_reg[load_addr];
                else if (sclk_fall && bit_cnt_reg != 3'd0)
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_mode_next = wr_mode_reg;
        ptr_next     = ptr_reg;
        load_addr    = ptr_reg;
        load_tx      = 1'b0;
        do_write     = 1'b0;
        if (ss_rise) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:   if (ss_fall) state_next = CMD;
                CMD: if (byte_done) begin
                    if (rx_byte == CMD_WRITE) begin
                        state_next   = ADDR;
                        wr_mode_next = 1'b1;
                    end else if (rx_byte == CMD_READ) begin
                        state_next   = ADDR;
                        wr_mode_next = 1'b0;
                    end else begin
                        state_next   = IGNORE;
                    end
                end
                ADDR: if (byte_done) begin
                    if (wr_mode_reg) begin
                        state_next = WDATA;
                        ptr_next   = rx_byte[5:0];
                    end else begin
                        state_next = RDATA;
                        load_addr  = rx_byte[5:0];
                        load_tx    = 1'b1;
                        ptr_next   = rx_byte[5:0] + 6'd1;
                    end
                end
                WDATA: if (byte_done) begin
                    do_write = 1'b1;
                    ptr_next = ptr_reg + 6'd1;
                end
                RDATA: if (byte_done) begin
                    load_tx  = 1'b1;
                    ptr_next = ptr_reg + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Samples reach the visible registers only while ss is high, so a burst never mixes two samples.
    assign shadow_next = bus.sample_valid ? {bus.z_sample, bus.y_sample, bus.x_sample} : shadow_reg;
    assign copy_en     = ss_s & (pending_reg | bus.sample_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) regs_reg[i] <= 8'h00;
            regs_reg[0]   <= DEVID_VAL;
            state_reg     <= IDLE;
            wr_mode_reg   <= 1'b0;
            ptr_reg       <= 6'd0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 8'h00;
            wr_data_reg   <= 8'h00;
            shadow_reg    <= 48'd0;
            pending_reg   <= 1'b0;
            clr_reg       <= 1'b0;
            int2_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_mode_reg   <= wr_mode_next;
            ptr_reg       <= ptr_next;
            wr_strobe_reg <= 1'b0;
            if (do_write && !is_ro(ptr_reg)) begin
                regs_reg[ptr_reg] <= rx_byte;
                wr_strobe_reg     <= 1'b1;
                wr_addr_reg       <= {2'b00, ptr_reg};
                wr_data_reg       <= rx_byte;
            end
            shadow_reg  <= shadow_next;
            pending_reg <= copy_en ? 1'b0 : (pending_reg | bus.sample_valid);
            if (ss_rise)
                clr_reg <= 1'b0;
            else if (load_tx && load_addr == ADDR_XL)
                clr_reg <= 1'b1;
            if (copy_en) begin
                for (int i = 0; i < 6; i++) regs_reg[ADDR_XL + 6'(i)] <= shadow_next[8*i +: 8];
                regs_reg[ADDR_STATUS][0] <= 1'b1;
            end else if (ss_rise && clr_reg) begin
                regs_reg[ADDR_STATUS][0] <= 1'b0;
            end
            int2_reg <= regs_reg[ADDR_STATUS][0] & (regs_reg[ADDR_PWR][1:0] == 2'b10);
        end
    end

    assign bus.miso      = ~ss_s & tx_shift_reg[7];
    assign bus.int2      = int2_reg;
    assign bus.wr_strobe = wr_strobe_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.power_ctl = regs_reg[ADDR_PWR];

endmodule

// File: tb/tb_acl2_spi_responder.sv
// Randomised scoreboard bench for acl2_spi_responder. A transaction-level register model produces the expected values.
// A monitor process compares every miso byte and every write strobe against the queues.
module tb_acl2_spi_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acl2_spi_responder_if bus();

    acl2_spi_responder #(.SYNC_STAGES(2), .DEVID_VAL(8'hAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    logic [7:0]  mdl_regs [64];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  act_rd_q [$];
    logic [15:0] exp_wr_q [$];
    logic [7:0]  tx_buf [16];
    logic [7:0]  wdata [8];
    int          tx_len;
    bit          mid_en;
    logic [47:0] mid_val;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference model: register map rules applied at whole-transaction granularity
    function automatic bit mdl_ro(input logic [5:0] a);
        return (a == 6'h00) || (a == 6'h0B) || (a >= 6'h0E && a <= 6'h13);
    endfunction

    function automatic logic mdl_int2();
        return mdl_regs[11][0] & (mdl_regs[45][1:0] == 2'b10);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 64; i++) mdl_regs[i] = 8'h00;
        mdl_regs[0] = 8'hAD;
    endtask

    task automatic mdl_copy(input logic [47:0] s);
        for (int k = 0; k < 6; k++) mdl_regs[14+k] = s[8*k +: 8];
        mdl_regs[11][0] = 1'b1;
    endtask

    task automatic pulse_sample(input logic [47:0] s);
        bus.x_sample     = s[15:0];
        bus.y_sample     = s[31:16];
        bus.z_sample     = s[47:32];
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    // One SPI bit time is 10 clk (sclk = clk/10). miso is captured just before the rising sclk.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            bus.mosi = tx[i];
            repeat (5) @(negedge clk);
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            repeat (5) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic run_txn();
        logic [7:0] rx;
        txn_no++;
        $display("txn %0d: cmd %h addr %h bytes %0d mid_sample %0d", txn_no, tx_buf[0], tx_buf[1], tx_len, mid_en);
        bus.ss = 1'b0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < tx_len; k++) begin
            spi_bits(tx_buf[k], 8, rx);
            act_rd_q.push_back(rx);
            if (mid_en && k == 2) pulse_sample(mid_val);
        end
        repeat (5) @(negedge clk);
        bus.ss = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic spi_write(input logic [7:0] ab, input int n);
        logic [5:0] p;
        p = ab[5:0];
        tx_buf[0] = 8'h0A;
        tx_buf[1] = ab;
        tx_len    = n + 2;
        mid_en    = 1'b0;
        for (int k = 0; k < n + 2; k++) exp_rd_q.push_back(8'h00);
        for (int k = 0; k < n; k++) begin
            tx_buf[k+2] = wdata[k];
            if (!mdl_ro(p)) begin
                mdl_regs[p] = wdata[k];
                exp_wr_q.push_back({2'b00, p, wdata[k]});
            end
            p = p + 6'd1;
        end
        run_txn();
    endtask

    task automatic spi_read(input logic [7:0] ab, input int n, input bit mid, input logic [47:0] mv);
        logic [5:0] p;
        bit clr;
        p   = ab[5:0];
        clr = 1'b0;
        tx_buf[0] = 8'h0B;
        tx_buf[1] = ab;
        tx_len    = n + 2;
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'h00);
        for (int k = 0; k < n; k++) begin
            tx_buf[k+2] = 8'($urandom);
            exp_rd_q.push_back(mdl_regs[p]);
            if (p == 6'h0E) clr = 1'b1;
            p = p + 6'd1;
        end
        if (p == 6'h0E) clr = 1'b1;   // the trailing reload after the last byte also counts
        mid_en  = mid;
        mid_val = mv;
        run_txn();
        if (clr) mdl_regs[11][0] = 1'b0;
        if (mid) mdl_copy(mv);           // set wins over the clear at ss rising
    endtask

    task automatic spi_junk(input logic [7:0] cmd, input int n);
        tx_buf[0] = cmd;
        tx_len    = n + 1;
        mid_en    = 1'b0;
        for (int k = 1; k <= n; k++) tx_buf[k] = 8'($urandom);
        for (int k = 0; k <= n; k++) exp_rd_q.push_back(8'h00);
        run_txn();
    endtask

    // Monitor: consumes DUT outputs and scores them against the expectation queues
    initial begin
        forever begin
            logic [15:0] e;
            logic [7:0]  a;
            @(negedge clk);
            if (bus.wr_strobe === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_event: got write %h=%h required none", bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_event", {bus.wr_addr, bus.wr_data}, e);
                end
            end
            while (act_rd_q.size() > 0) begin
                a = act_rd_q.pop_front();
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_byte: got %h required none", a);
                end else begin
                    check("miso_byte", {8'h00, a}, {8'h00, exp_rd_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [7:0]  rx;
        logic [47:0] sa, sb;
        logic [7:0]  ab, c;
        int          r, n;
        bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        bus.sample_valid = 1'b0;
        bus.x_sample = 16'h0; bus.y_sample = 16'h0; bus.z_sample = 16'h0;
        mid_en = 1'b0; mid_val = 48'd0;
        rst = 1'b1;
        mdl_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_miso",      {15'd0, bus.miso},      16'h0);
        check("rst_int2",      {15'd0, bus.int2},      16'h0);
        check("rst_wr_strobe", {15'd0, bus.wr_strobe}, 16'h0);
        check("rst_wr_addr",   {8'd0, bus.wr_addr},    16'h0);
        check("rst_wr_data",   {8'd0, bus.wr_data},    16'h0);
        check("rst_power_ctl", {8'd0, bus.power_ctl},  16'h0);

        // Write POWER_CTL, then read DEVID and the still-empty sample area
        wdata[0] = 8'h0A;
        spi_write(8'h2D, 1);
        check("power_ctl_write", {8'd0, bus.power_ctl}, {8'd0, mdl_regs[45]});
        spi_read(8'h00, 1, 1'b0, 48'd0);
        spi_read(8'h0E, 1, 1'b0, 48'd0);

        // Data-ready path and coherent burst
        pulse_sample(48'h00FF_FFF0_0123);
        mdl_copy(48'h00FF_FFF0_0123);
        repeat (4) @(negedge clk);
        check("int2_set", {15'd0, bus.int2}, {15'd0, mdl_int2()});
        spi_read(8'h0E, 6, 1'b0, 48'd0);
        check("int2_cleared", {15'd0, bus.int2}, {15'd0, mdl_int2()});

        sa = {16'($urandom), 16'($urandom), 16'($urandom)};
        sb = {16'($urandom), 16'($urandom), 16'($urandom)};
        pulse_sample(sa);
        mdl_copy(sa);
        repeat (4) @(negedge clk);
        spi_read(8'h0E, 6, 1'b1, sb);
        check("int2_after_mid_sample", {15'd0, bus.int2}, {15'd0, mdl_int2()});
        spi_read(8'h0E, 6, 1'b0, 48'd0);

        // Pointer wrap into read-only DEVID, then an unknown command
        wdata[0] = 8'h11; wdata[1] = 8'h22;
        spi_write(8'h3F, 2);
        spi_read(8'h3F, 2, 1'b0, 48'd0);
        spi_junk(8'h55, 4);

        // Aborted data byte must not write
        wdata[0] = 8'h5A;
        spi_write(8'h22, 1);
        bus.ss = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h22, 8, rx);
        spi_bits(8'hA5, 4, rx);
        repeat (5) @(negedge clk);
        bus.ss = 1'b1;
        repeat (12) @(negedge clk);
        spi_read(8'h22, 1, 1'b0, 48'd0);

        // Reset in the middle of a read
        bus.ss = 1'b0;
        repeat (5) @(negedge clk);
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h2D, 8, rx);
        spi_bits(8'h00, 4, rx);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("miso_in_rst", {15'd0, bus.miso}, 16'h0);
        rst = 1'b0;
        mdl_reset();
        @(negedge clk);
        check("miso_after_rst", {15'd0, bus.miso}, 16'h0);
        bus.ss = 1'b1;
        repeat (12) @(negedge clk);
        check("power_ctl_after_rst", {8'd0, bus.power_ctl}, {8'd0, mdl_regs[45]});
        spi_read(8'h00, 2, 1'b0, 48'd0);

        // Randomised mix
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            ab = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'h0A, 8'h14)) : 8'($urandom);
            n  = $urandom_range(1, 5);
            if (r <= 2) begin
                for (int k = 0; k < 8; k++) wdata[k] = 8'($urandom);
                spi_write(ab, n);
            end else if (r == 3) begin
                wdata[0] = {6'($urandom), 2'($urandom_range(1, 2))};
                spi_write(8'h2D, 1);
            end else if (r <= 6) begin
                sb = {16'($urandom), 16'($urandom), 16'($urandom)};
                spi_read(ab, n + 1, ($urandom_range(0, 1) == 1), sb);
            end else if (r <= 8) begin
                sa = {16'($urandom), 16'($urandom), 16'($urandom)};
                pulse_sample(sa);
                mdl_copy(sa);
                repeat (4) @(negedge clk);
            end else begin
                c = 8'($urandom);
                if (c == 8'h0A || c == 8'h0B) c = c ^ 8'h80;
                spi_junk(c, n);
            end
            check("int2_rand", {15'd0, bus.int2}, {15'd0, mdl_int2()});
            check("power_ctl_rand", {8'd0, bus.power_ctl}, {8'd0, mdl_regs[45]});
        end

        repeat (20) @(negedge clk);
        check("wr_queue_drained", 16'(exp_wr_q.size()), 16'h0);
        check("rd_queue_drained", 16'(exp_rd_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
